// File: rtl/sasanqua_test_pkg.sv
// Shared types for the riscv-tests pass/fail monitor: FSM states, status codes
// and result-word layout {id[31:24], status[23:22], fail_idx[21:0]}.
package sasanqua_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_RUN,
    S_SETTLE,
    S_JUDGE
  } mon_state_e;

  localparam logic [1:0] ST_PASS    = 2'b00;
  localparam logic [1:0] ST_FAIL    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam int RES_ID_LSB     = 24;
  localparam int RES_STATUS_LSB = 22;
  localparam int RES_IDX_LSB    = 0;
  localparam int RES_IDX_W      = 22;

  function automatic logic [31:0] pack_result(input logic [7:0] id,
                                              input logic [1:0] status,
                                              input logic [RES_IDX_W-1:0] fail_idx);
    logic [31:0] w;
    w = '0;
    w[RES_ID_LSB +: 8]            = id;
    w[RES_STATUS_LSB +: 2]        = status;
    w[RES_IDX_LSB +: RES_IDX_W]   = fail_idx;
    return w;
  endfunction

endpackage

// File: rtl/monitor_result_fifo.sv
// Synchronous result FIFO: same-cycle push/pop (a pop frees room for a push when full),
// registered read data held until the next pop, sticky overflow on a dropped push.
module monitor_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             rd_vld_q, rd_vld_d;
  logic [WIDTH-1:0] rd_dat_q, rd_dat_d;
  logic             overflow_q, overflow_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_vld_d   = do_pop;
    rd_dat_d   = rd_dat_q;
    overflow_d = overflow_q || (push && !do_push);
    if (do_pop) begin
      rd_dat_d = mem_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_vld_q   <= 1'b0;
      rd_dat_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_vld_q   <= rd_vld_d;
      rd_dat_q   <= rd_dat_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_vld   = rd_vld_q;
  assign rd_dat   = rd_dat_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/riscv_test_monitor.sv
// riscv-tests pass/fail monitor: resets the core, waits for the END_PC jump, judges gp
// and logs a result word. RISCV_TEST_MONITOR_TIMEOUT_EN enables the RUN timeout.
module riscv_test_monitor
  import sasanqua_test_pkg::*;
#(
  parameter logic [31:0] END_PC          = 32'h2000_003C,
  parameter int          CORE_RST_CYCLES = 10,
  parameter int          SETTLE_CYCLES   = 10,
  parameter int          TIMEOUT_CYCLES  = 1_000_000,
  parameter int          LOG_DEPTH       = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  TEST_ID,
  output logic        CORE_RST,
  input  logic        JMP_DO,
  input  logic [31:0] JMP_PC,
  input  logic [31:0] GP_DATA,
  output logic        BUSY,
  input  logic        RES_RDEN,
  output logic        RES_VALID,
  output logic [31:0] RES_DATA,
  output logic        RES_EMPTY,
  output logic        RES_FULL,
  output logic        OVERFLOW,
  output logic [15:0] PASS_COUNT,
  output logic [15:0] FAIL_COUNT
);

  localparam logic [31:0] CRST_LAST   = 32'(CORE_RST_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
`ifdef RISCV_TEST_MONITOR_TIMEOUT_EN
  localparam logic [31:0] TO_LAST     = 32'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  mon_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  id_q, id_d;
  logic        core_rst_q, core_rst_d;
  logic        timeout_q, timeout_d;
  logic [15:0] pass_cnt_q, pass_cnt_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;
  logic        push;
  logic [1:0]  status;
  logic [21:0] fail_idx;
  logic [31:0] res_word;
  logic        end_hit;

  assign end_hit = JMP_DO && (JMP_PC == END_PC);

  always_comb begin
    status   = ST_PASS;
    fail_idx = '0;
    if (timeout_q) begin
      status = ST_TIMEOUT;
    end else if (GP_DATA != 32'd1) begin
      status   = ST_FAIL;
      fail_idx = GP_DATA[22:1];
    end
    res_word = pack_result(id_q, status, fail_idx);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    core_rst_d = core_rst_q;
    timeout_d  = timeout_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          id_d       = TEST_ID;
          cnt_d      = '0;
          core_rst_d = 1'b1;
          timeout_d  = 1'b0;
          state_d    = S_CRST;
        end
      end
      S_CRST: begin
        if (cnt_q == CRST_LAST) begin
          cnt_d      = '0;
          core_rst_d = 1'b0;
          state_d    = S_RUN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        // End detection wins over a coincident timeout.
        if (end_hit) begin
          cnt_d   = '0;
          state_d = (SETTLE_CYCLES == 0) ? S_JUDGE : S_SETTLE;
`ifdef RISCV_TEST_MONITOR_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_JUDGE;
        end else begin
          cnt_d = cnt_q + 32'd1;
`endif
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_JUDGE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_JUDGE: begin
        push = 1'b1;
        if (status == ST_PASS) begin
          if (pass_cnt_q != 16'hFFFF) pass_cnt_d = pass_cnt_q + 16'd1;
        end else begin
          if (fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      id_q       <= '0;
      core_rst_q <= 1'b1;
      timeout_q  <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      core_rst_q <= core_rst_d;
      timeout_q  <= timeout_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  monitor_result_fifo #(
    .WIDTH (32),
    .DEPTH (LOG_DEPTH)
  ) u_result_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (push),
    .push_dat (res_word),
    .pop      (RES_RDEN),
    .rd_vld   (RES_VALID),
    .rd_dat   (RES_DATA),
    .empty    (RES_EMPTY),
    .full     (RES_FULL),
    .overflow (OVERFLOW)
  );

  assign CORE_RST   = core_rst_q;
  assign BUSY       = (state_q != S_IDLE);
  assign PASS_COUNT = pass_cnt_q;
  assign FAIL_COUNT = fail_cnt_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: table of pass/fail vectors plus
// sequences for FIFO overflow, hang/timeout and mid-test reset.
module tb_riscv_test_monitor;

  localparam logic [31:0] END_PC = 32'h2000_003C;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [7:0]  TEST_ID;
  logic        CORE_RST;
  logic        JMP_DO;
  logic [31:0] JMP_PC;
  logic [31:0] GP_DATA;
  logic        BUSY;
  logic        RES_RDEN;
  logic        RES_VALID;
  logic [31:0] RES_DATA;
  logic        RES_EMPTY;
  logic        RES_FULL;
  logic        OVERFLOW;
  logic [15:0] PASS_COUNT;
  logic [15:0] FAIL_COUNT;

  int errors = 0;
  int checks = 0;
  int exp_pass = 0;
  int exp_fail = 0;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] gp;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  riscv_test_monitor #(
    .END_PC          (END_PC),
    .CORE_RST_CYCLES (10),
    .SETTLE_CYCLES   (10),
    .TIMEOUT_CYCLES  (100),
    .LOG_DEPTH       (2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .TEST_ID    (TEST_ID),
    .CORE_RST   (CORE_RST),
    .JMP_DO     (JMP_DO),
    .JMP_PC     (JMP_PC),
    .GP_DATA    (GP_DATA),
    .BUSY       (BUSY),
    .RES_RDEN   (RES_RDEN),
    .RES_VALID  (RES_VALID),
    .RES_DATA   (RES_DATA),
    .RES_EMPTY  (RES_EMPTY),
    .RES_FULL   (RES_FULL),
    .OVERFLOW   (OVERFLOW),
    .PASS_COUNT (PASS_COUNT),
    .FAIL_COUNT (FAIL_COUNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    RES_RDEN = 1'b1;
    step();
    RES_RDEN = 1'b0;
    chk({name, "_valid"}, RES_VALID, 1);
    chk({name, "_data"}, RES_DATA, exp);
  endtask

  task automatic wait_run(input string name);
    int n;
    n = 0;
    while (CORE_RST && n < 100) begin
      n++;
      step();
    end
    chk(name, n, 10);
  endtask

  // mode 0: pop after push, 1: leave in FIFO, 2: pop on the JUDGE cycle
  task automatic run_test(input logic [7:0] id, input logic [31:0] gp, input logic [31:0] exp,
                          input int mode, input logic [31:0] exp_pop);
    int n;
    START   = 1'b1;
    TEST_ID = id;
    step();
    START   = 1'b0;
    chk("busy_after_start", BUSY, 1);
    n = 0;
    while (CORE_RST && n < 100) begin
      START   = (n == 3);
      TEST_ID = ~id;
      n++;
      step();
    end
    START = 1'b0;
    chk("core_rst_width", n, 10);
    JMP_DO = 1'b0; JMP_PC = END_PC; GP_DATA = 32'hDEAD_BEEF;
    step();
    JMP_DO = 1'b1; JMP_PC = END_PC ^ 32'h4;
    step();
    JMP_DO = 1'b1; JMP_PC = END_PC;
    step();
    JMP_DO = 1'b0; JMP_PC = '0;
    repeat (10) step();
    chk("busy_in_judge", BUSY, 1);
    if (mode == 0) chk("empty_before_push", RES_EMPTY, 1);
    chk("pass_cnt_before_push", PASS_COUNT, exp_pass);
    GP_DATA = gp;
    if (mode == 2) RES_RDEN = 1'b1;
    step();
    GP_DATA  = 32'hDEAD_BEEF;
    RES_RDEN = 1'b0;
    if (exp[23:22] == 2'b00) exp_pass++;
    else exp_fail++;
    chk("busy_after_judge", BUSY, 0);
    chk("core_rst_after_test", CORE_RST, 0);
    chk("pass_count", PASS_COUNT, exp_pass);
    chk("fail_count", FAIL_COUNT, exp_fail);
    if (mode == 0) begin
      chk("empty_after_push", RES_EMPTY, 0);
      pop_check("pop", exp);
      step();
      chk("valid_pulse_end", RES_VALID, 0);
      chk("data_hold", RES_DATA, exp);
      chk("empty_after_pop", RES_EMPTY, 1);
    end
    if (mode == 2) begin
      chk("judge_pop_valid", RES_VALID, 1);
      chk("judge_pop_data", RES_DATA, exp_pop);
      chk("judge_pop_full", RES_FULL, 1);
      chk("judge_pop_no_overflow", OVERFLOW, 0);
    end
  endtask

  initial begin
    vecs[0] = '{id: 8'h05, gp: 32'h0000_0001, exp: 32'h0500_0000};
    vecs[1] = '{id: 8'h0C, gp: 32'h0000_0007, exp: 32'h0C40_0003};
    vecs[2] = '{id: 8'h3A, gp: 32'h0000_0000, exp: 32'h3A40_0000};
    vecs[3] = '{id: 8'hFF, gp: 32'hFFFF_FFFF, exp: 32'hFF7F_FFFF};
    vecs[4] = '{id: 8'h80, gp: 32'h0000_0001, exp: 32'h8000_0000};
    vecs[5] = '{id: 8'h11, gp: 32'h0000_0002, exp: 32'h1140_0001};
    vecs[6] = '{id: 8'h22, gp: 32'h0080_0000, exp: 32'h2240_0000};

    RST = 1'b0; START = 1'b0; TEST_ID = '0; JMP_DO = 1'b0; JMP_PC = '0;
    GP_DATA = '0; RES_RDEN = 1'b0;
    do_reset();

    chk("rst_busy", BUSY, 0);
    chk("rst_core_rst", CORE_RST, 1);
    chk("rst_res_valid", RES_VALID, 0);
    chk("rst_res_data", RES_DATA, 0);
    chk("rst_empty", RES_EMPTY, 1);
    chk("rst_full", RES_FULL, 0);
    chk("rst_overflow", OVERFLOW, 0);
    chk("rst_pass_count", PASS_COUNT, 0);
    chk("rst_fail_count", FAIL_COUNT, 0);
    repeat (3) step();
    chk("idle_core_rst_held", CORE_RST, 1);

    RES_RDEN = 1'b1;
    step();
    RES_RDEN = 1'b0;
    chk("pop_empty_valid", RES_VALID, 0);
    chk("pop_empty_data", RES_DATA, 0);

    for (int i = 0; i < 7; i++) begin
      run_test(vecs[i].id, vecs[i].gp, vecs[i].exp, 0, 32'h0);
    end

    // Overflow: three pushes into a two-entry FIFO
    run_test(8'hA1, 32'h1, 32'hA100_0000, 1, 32'h0);
    run_test(8'hA2, 32'h1, 32'hA200_0000, 1, 32'h0);
    chk("ovf_not_yet", OVERFLOW, 0);
    run_test(8'hA3, 32'h1, 32'hA300_0000, 1, 32'h0);
    chk("ovf_full", RES_FULL, 1);
    chk("ovf_set", OVERFLOW, 1);
    pop_check("ovf_pop0", 32'hA100_0000);
    pop_check("ovf_pop1", 32'hA200_0000);
    step();
    chk("ovf_drained", RES_EMPTY, 1);
    chk("ovf_sticky", OVERFLOW, 1);

    // Pop coinciding with the third push keeps all entries
    do_reset();
    chk("ovf_cleared", OVERFLOW, 0);
    run_test(8'hB1, 32'h1, 32'hB100_0000, 1, 32'h0);
    run_test(8'hB2, 32'h1, 32'hB200_0000, 1, 32'h0);
    run_test(8'hB3, 32'h1, 32'hB300_0000, 2, 32'hB100_0000);
    pop_check("sim_pop0", 32'hB200_0000);
    pop_check("sim_pop1", 32'hB300_0000);
    step();
    chk("sim_drained", RES_EMPTY, 1);
    chk("sim_no_overflow", OVERFLOW, 0);

    // No end jump: timeout verdict or indefinite wait
    START = 1'b1; TEST_ID = 8'h77;
    step();
    START = 1'b0;
    wait_run("hang_run_entry");
`ifdef RISCV_TEST_MONITOR_TIMEOUT_EN
    repeat (100) step();
    chk("to_busy_judge", BUSY, 1);
    chk("to_empty_judge", RES_EMPTY, 1);
    step();
    chk("to_idle", BUSY, 0);
    chk("to_logged", RES_EMPTY, 0);
    exp_fail++;
    chk("to_fail_count", FAIL_COUNT, exp_fail);
    pop_check("to_pop", 32'h7780_0000);
    START = 1'b1; TEST_ID = 8'h66;
    step();
    START = 1'b0;
    wait_run("rst_test_run_entry");
`else
    repeat (1000) step();
    chk("hang_busy", BUSY, 1);
    chk("hang_empty", RES_EMPTY, 1);
`endif

    // Reset in the middle of RUN
    repeat (5) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
    chk("midrst_busy", BUSY, 0);
    chk("midrst_core_rst", CORE_RST, 1);
    chk("midrst_empty", RES_EMPTY, 1);
    chk("midrst_pass", PASS_COUNT, 0);
    chk("midrst_fail", FAIL_COUNT, 0);
    chk("midrst_valid", RES_VALID, 0);
    run_test(8'h05, 32'h1, 32'h0500_0000, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable pass/fail checker for riscv-tests programs running on the core. It drives the core reset and watches the core's jump stream for the end-of-test PC. After a settle delay it judges x3 (gp) and logs a result word per test into a small FIFO. It sits beside `core` at the top level, so regression runs on hardware or in simulation need no hierarchical probes.

## Interface
Parameters:
- `END_PC`, 32'h2000_003C: jump target that marks test completion.
- `CORE_RST_CYCLES`, 10: cycles `CORE_RST` is held high per test (≥1).
- `SETTLE_CYCLES`, 10: cycles waited after end detection before sampling gp (≥0).
- `TIMEOUT_CYCLES`, 1_000_000: max RUN cycles before a timeout verdict (≥1).
- `LOG_DEPTH`, 8: result FIFO entries (power of two, ≥2).

Ports:
- `CLK` in 1: clock. Single clock domain.
- `RST` in 1: reset, synchronous, active-high.
- `START` in 1: begin a test. Accepted only when `BUSY`=0.
- `TEST_ID` in 8: identifier captured with `START`.
- `CORE_RST` out 1: reset to the core under test.
- `JMP_DO` in 1: core jump-taken strobe (mem stage).
- `JMP_PC` in 32: jump target, qualified by `JMP_DO`.
- `GP_DATA` in 32: live value of register x3.
- `BUSY` out 1: a test is in progress.
- `RES_RDEN` in 1: pop the result FIFO.
- `RES_VALID` out 1: `RES_DATA` valid, one-cycle pulse.
- `RES_DATA` out 32: {id[31:24], status[23:22], fail_idx[21:0]}.
- `RES_EMPTY` out 1: FIFO empty.
- `RES_FULL` out 1: FIFO full.
- `OVERFLOW` out 1: sticky; set when a result is dropped.
- `PASS_COUNT` out 16: saturating count of passes.
- `FAIL_COUNT` out 16: saturating count of fails plus timeouts.

## Operation
- FSM states: IDLE, CRST, RUN, SETTLE, JUDGE.
- IDLE: on `START`, capture `TEST_ID`, go to CRST.
- CRST: `CORE_RST`=1 for exactly `CORE_RST_CYCLES` cycles, then go to RUN.
- RUN:
  - Clear the timeout counter on entry and count up each cycle.
  - `JMP_DO`=1 with `JMP_PC`==`END_PC` → SETTLE.
  - Counter reaches `TIMEOUT_CYCLES`-1 → JUDGE with the timeout flag set.
  - End detection takes priority when both happen in the same cycle.
- SETTLE: wait `SETTLE_CYCLES` cycles, then go to JUDGE. With 0, go straight to JUDGE.
- JUDGE: compute the result and push it, then return to IDLE.
  - Status 2'b10: timeout.
  - Else status 2'b00 (pass) if `GP_DATA`==1.
  - Else status 2'b01 (fail), with fail_idx = `GP_DATA`[22:1].
  - fail_idx is 0 for pass and for timeout.
- Counters saturate at 16'hFFFF and never wrap.
- FIFO:
  - Push when full drops the entry and sets `OVERFLOW`. A pop in the same cycle frees a slot first, so the push then succeeds.
  - Pop when empty is ignored and `RES_VALID` stays 0.
- `START` outside IDLE is ignored.
- `BUSY` = state≠IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `CORE_RST`=1, so the core is held in reset until the first test.
  - `BUSY`=0, `RES_VALID`=0, `RES_DATA`=0.
  - `RES_EMPTY`=1, `RES_FULL`=0, `OVERFLOW`=0.
  - Both counters 0.
  - FIFO pointers 0.
- `CORE_RST` drops the cycle after the final CRST cycle and stays low through RUN, SETTLE and JUDGE. It rises again only on the next CRST or on `RST`.
- `START` seen at edge n → `BUSY`=1 at n+1 and CRST occupies n+1 … n+`CORE_RST_CYCLES`.
- End detection at edge m → gp sampled at edge m+`SETTLE_CYCLES`+1 (JUDGE). The entry is visible (`RES_EMPTY`=0) and the counter is updated at m+`SETTLE_CYCLES`+2.
- `RES_RDEN` at edge k → `RES_DATA`/`RES_VALID` registered at k+1. Output data holds until the next pop.
- `RST` at any point, including mid-test, aborts the test. No partial result is logged, and all state returns to reset values next cycle.

## Configuration
- `RISCV_TEST_MONITOR_TIMEOUT_EN`:
  - Defined: the timeout counter and status 2'b10 exist as described.
  - Undefined: the counter is removed, RUN waits indefinitely for `END_PC`, and status 2'b10 is never produced. `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `sasanqua_test_pkg`:
  - FSM state enum.
  - Status codes `ST_PASS`, `ST_FAIL`, `ST_TIMEOUT`.
  - Result-word field offsets.
- Sub-module `monitor_result_fifo`: synchronous FIFO with same-cycle push/pop, full/empty flags and registered read data. It is parameterised by width 32 and depth `LOG_DEPTH`.

## Test plan
- Pass: `START` with id 8'h05, drive jump to 32'h2000_003C, `GP_DATA`=1 → after the settle delay, a pop gives `RES_DATA`=32'h0500_0000 and `PASS_COUNT`=1.
- Fail: id 8'h0C, `GP_DATA`=32'h0000_0007 at judge → `RES_DATA`=32'h0C40_0003 and `FAIL_COUNT`=1.
- Timeout (macro on, `TIMEOUT_CYCLES`=100): no end jump → status 2'b10 logged exactly 100 cycles after RUN entry. With the macro off, `BUSY` stays 1 after 1000 cycles.
- Overflow: `LOG_DEPTH`=2, run 3 passing tests without popping → 2 entries kept and `OVERFLOW`=1. A pop on the third push's JUDGE cycle keeps 2 entries with `OVERFLOW`=0.
- Reset mid-RUN: assert `RST` for 1 cycle → next cycle IDLE, `CORE_RST`=1, `RES_EMPTY`=1, counters 0. A following `START` runs normally.
- `CORE_RST` width: `CORE_RST_CYCLES`=10 → after `START` the core reset is high for exactly 10 cycles. A second `START` while `BUSY` is ignored.
